// File: rtl/cu_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack and
// presents IR/PC to decode over valid/ready. Optional request timeout under FETCH_TIMEOUT_EN.
module cu_fetch #(
  parameter int unsigned IMEM_DEPTH = 128,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned MAX_WAIT   = 15
) (
  input  logic        soc_clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir_out,
  output logic [31:0] ir_pc,
  output logic        pc_fault,
  output logic        fetch_timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HOLD, ST_FAULT} state_t;

  localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_DEPTH);

  if (MAX_WAIT < 1) begin : g_max_wait_check
    $error("MAX_WAIT must be at least 1");
  end

  state_t      r_state, w_state_nx;
  logic [31:0] r_pc, w_pc_nx;
  logic [31:0] r_mem_addr, w_mem_addr_nx;
  logic [31:0] r_ir_out, w_ir_out_nx;
  logic [31:0] r_ir_pc, w_ir_pc_nx;
  logic        r_mem_req, w_mem_req_nx;
  logic        r_ir_valid, w_ir_valid_nx;
  logic        r_pc_fault, w_pc_fault_nx;
  logic        r_squash, w_squash_nx;
  logic        w_pc_illegal;
  logic        w_timeout_hit;

  assign w_pc_illegal = (r_pc[1:0] != 2'b00) || (r_pc >= PC_LIMIT);

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned WAIT_W = ($clog2(MAX_WAIT + 1) < 4) ? 4 : $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] r_wait;
  logic              r_fetch_timeout;

  // Counter idles at zero outside REQ, so it is already clear on entry to REQ.
  assign w_timeout_hit = (r_state == ST_REQ) && !mem_ack && (r_wait == WAIT_W'(MAX_WAIT - 1));

  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      r_wait          <= '0;
      r_fetch_timeout <= 1'b0;
    end else begin
      if (r_state != ST_REQ)
        r_wait <= '0;
      else if (!mem_ack)
        r_wait <= r_wait + WAIT_W'(1);
      if (w_timeout_hit)
        r_fetch_timeout <= 1'b1;
    end
  end

  assign fetch_timeout = r_fetch_timeout;
`else
  assign w_timeout_hit = 1'b0;
  assign fetch_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nx    = r_state;
    w_pc_nx       = r_pc;
    w_mem_addr_nx = r_mem_addr;
    w_ir_out_nx   = r_ir_out;
    w_ir_pc_nx    = r_ir_pc;
    w_mem_req_nx  = r_mem_req;
    w_ir_valid_nx = r_ir_valid;
    w_pc_fault_nx = r_pc_fault;
    w_squash_nx   = r_squash;
    case (r_state)
      ST_IDLE: begin
        if (redirect_valid) begin
          w_pc_nx = redirect_pc;
        end else if (fetch_en && !stall) begin
          if (w_pc_illegal) begin
            w_state_nx    = ST_FAULT;
            w_pc_fault_nx = 1'b1;
          end else begin
            w_state_nx    = ST_REQ;
            w_mem_req_nx  = 1'b1;
            w_mem_addr_nx = r_pc;
            w_squash_nx   = 1'b0;
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          w_mem_req_nx = 1'b0;
          // A redirect arriving with the ack kills the word just like an earlier one.
          if (redirect_valid || r_squash) begin
            w_squash_nx = 1'b0;
            w_state_nx  = ST_IDLE;
          end else begin
            w_ir_out_nx   = mem_rdata;
            w_ir_pc_nx    = r_pc;
            w_ir_valid_nx = 1'b1;
            w_pc_nx       = r_pc + 32'd4;
            w_state_nx    = ST_HOLD;
          end
        end else if (w_timeout_hit) begin
          w_mem_req_nx  = 1'b0;
          w_pc_fault_nx = 1'b1;
          w_state_nx    = ST_FAULT;
        end else if (redirect_valid) begin
          w_squash_nx = 1'b1;
        end
        if (redirect_valid)
          w_pc_nx = redirect_pc;
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          w_pc_nx       = redirect_pc;
          w_ir_valid_nx = 1'b0;
          w_state_nx    = ST_IDLE;
        end else if (ir_ready) begin
          w_ir_valid_nx = 1'b0;
          w_state_nx    = ST_IDLE;
        end
      end
      ST_FAULT: begin
        w_mem_req_nx  = 1'b0;
        w_ir_valid_nx = 1'b0;
        w_pc_fault_nx = 1'b1;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_mem_addr <= '0;
      r_ir_out   <= '0;
      r_ir_pc    <= '0;
      r_mem_req  <= 1'b0;
      r_ir_valid <= 1'b0;
      r_pc_fault <= 1'b0;
      r_squash   <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pc       <= w_pc_nx;
      r_mem_addr <= w_mem_addr_nx;
      r_ir_out   <= w_ir_out_nx;
      r_ir_pc    <= w_ir_pc_nx;
      r_mem_req  <= w_mem_req_nx;
      r_ir_valid <= w_ir_valid_nx;
      r_pc_fault <= w_pc_fault_nx;
      r_squash   <= w_squash_nx;
    end
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign ir_valid = r_ir_valid;
  assign ir_out   = r_ir_out;
  assign ir_pc    = r_ir_pc;
  assign pc_fault = r_pc_fault;

endmodule

// File: tb/tb_cu_fetch.sv
// Directed bench for cu_fetch: expected {pc, word} pairs are queued when memory acks
// and popped when decode accepts. Build with FETCH_TIMEOUT_EN to exercise the timeout.
module tb_cu_fetch;

  logic        soc_clk = 1'b0;
  logic        reset;
  logic        fetch_en, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_rdata;
  logic        ir_valid, ir_ready;
  logic [31:0] ir_out, ir_pc;
  logic        pc_fault, fetch_timeout;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [63:0] sb_q[$];

  always #5 soc_clk = ~soc_clk;

  cu_fetch #(.IMEM_DEPTH(128), .RESET_PC(32'h0000_0000), .MAX_WAIT(15)) dut (
    .soc_clk(soc_clk), .reset(reset), .fetch_en(fetch_en), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_out(ir_out), .ir_pc(ir_pc),
    .pc_fault(pc_fault), .fetch_timeout(fetch_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge soc_clk);
  endtask

  task automatic wait_req(input string tag);
    int unsigned i = 0;
    while (mem_req !== 1'b1 && i < 50) begin
      step();
      i++;
    end
    chk1({tag, "_req_seen"}, mem_req, 1'b1);
  endtask

  // Waits for a request at exp_addr, holds off the ack for 'delay' cycles, then acks.
  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                          input int unsigned delay, input bit keep);
    wait_req("fetch");
    chk("mem_addr", mem_addr, exp_addr);
    for (int unsigned i = 0; i < delay; i++) begin
      step();
      chk1("req_held", mem_req, 1'b1);
      chk("addr_stable", mem_addr, exp_addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = data;
    if (keep) sb_q.push_back({exp_addr, data});
    step();
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  // Holds ir_ready low for 'hold' cycles, then accepts the presented word.
  task automatic accept(input int unsigned hold);
    logic [63:0] e;
    chk1("ir_valid_up", ir_valid, 1'b1);
    chk("sb_nonempty", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    for (int unsigned i = 0; i < hold; i++) begin
      chk("hold_ir_out", ir_out, e[31:0]);
      chk1("hold_no_req", mem_req, 1'b0);
      step();
    end
    chk("ir_out", ir_out, e[31:0]);
    chk("ir_pc", ir_pc, e[63:32]);
    chk1("ir_valid_held", ir_valid, 1'b1);
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    chk1("ir_valid_drop", ir_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; fetch_en = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; mem_ack = 1'b0; mem_rdata = '0; ir_ready = 1'b0;
    repeat (2) step();
    chk1("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk1("rst_ir_valid", ir_valid, 1'b0);
    chk("rst_ir_out", ir_out, 32'h0);
    chk("rst_ir_pc", ir_pc, 32'h0);
    chk1("rst_pc_fault", pc_fault, 1'b0);
    chk1("rst_timeout", fetch_timeout, 1'b0);
    reset = 1'b0;
    fetch_en = 1'b1;

    // First fetch from reset PC, decode stalls 5 cycles in HOLD
    do_fetch(32'h0, 32'h0050_0093, 0, 1);
    accept(5);
    do_fetch(32'h4, 32'h00A0_0113, 1, 1);
    accept(0);

    // Redirect while in REQ, ack two cycles later: word must be dropped
    wait_req("redir_req");
    chk("redir_req_addr", mem_addr, 32'h8);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk1("redir_req_held", mem_req, 1'b1);
    chk("redir_addr_held", mem_addr, 32'h8);
    chk1("redir_no_valid", ir_valid, 1'b0);
    step();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0;
    chk1("squash_no_valid", ir_valid, 1'b0);
    chk1("squash_req_drop", mem_req, 1'b0);
    do_fetch(32'h40, 32'h0000_0013, 0, 1);
    accept(0);

    // Redirect coinciding with ack in REQ
    wait_req("redir_ack");
    chk("redir_ack_addr", mem_addr, 32'h44);
    redirect_valid = 1'b1; redirect_pc = 32'h100; mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    step();
    redirect_valid = 1'b0; mem_ack = 1'b0;
    chk1("redir_ack_no_valid", ir_valid, 1'b0);
    chk1("redir_ack_no_req", mem_req, 1'b0);
    do_fetch(32'h100, 32'h0010_8093, 0, 1);
    accept(0);

    // Stall blocks issue from IDLE only
    stall = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      chk1("stall_no_req", mem_req, 1'b0);
    end
    stall = 1'b0;
    step();
    chk1("stall_release_req", mem_req, 1'b1);
    chk("stall_release_addr", mem_addr, 32'h104);

    // Outstanding request completes under stall; redirect in HOLD beats ir_ready
    stall = 1'b1;
    do_fetch(32'h104, 32'h2222_2222, 1, 0);
    chk1("stall_hold_valid", ir_valid, 1'b1);
    chk("stall_hold_out", ir_out, 32'h2222_2222);
    redirect_valid = 1'b1; redirect_pc = 32'h1FC; ir_ready = 1'b1;
    step();
    redirect_valid = 1'b0; ir_ready = 1'b0;
    chk1("hold_redir_drop", ir_valid, 1'b0);
    step();
    chk1("hold_redir_stalled", mem_req, 1'b0);
    stall = 1'b0;

    // Last legal word, then pc+4 reaches 0x200 and faults on issue
    do_fetch(32'h1FC, 32'h3333_3333, 0, 1);
    accept(0);
    step();
    chk1("range_fault", pc_fault, 1'b1);
    chk1("range_fault_no_req", mem_req, 1'b0);
    reset = 1'b1;
    #1;
    chk1("async_rst_fault", pc_fault, 1'b0);
    step();
    reset = 1'b0;

    // Misaligned redirect target: faults at issue, not at redirect
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
    chk1("misalign_not_yet", pc_fault, 1'b0);
    chk1("misalign_no_req", mem_req, 1'b0);
    step();
    chk1("misalign_fault", pc_fault, 1'b1);
    reset = 1'b1; fetch_en = 1'b0;
    step();
    reset = 1'b0;

    // Redirect to 0x200 with fetching disabled, then enable
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk1("r200_not_yet", pc_fault, 1'b0);
    fetch_en = 1'b1;
    step();
    chk1("r200_fault", pc_fault, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      chk1("fault_sticky", pc_fault, 1'b1);
      chk1("fault_no_req", mem_req, 1'b0);
      chk1("fault_no_valid", ir_valid, 1'b0);
    end
    reset = 1'b1;
    step();
    chk1("rst_clears_fault", pc_fault, 1'b0);
    reset = 1'b0;
    do_fetch(32'h0, 32'h0050_0093, 0, 1);
    accept(0);

    // Memory never acks
    wait_req("to_req");
    chk("to_addr", mem_addr, 32'h4);
`ifdef FETCH_TIMEOUT_EN
    for (int unsigned i = 0; i < 14; i++) begin
      step();
      chk1("to_not_yet", fetch_timeout, 1'b0);
      chk1("to_req_held", mem_req, 1'b1);
    end
    step();
    chk1("to_flag", fetch_timeout, 1'b1);
    chk1("to_pc_fault", pc_fault, 1'b1);
    chk1("to_req_drop", mem_req, 1'b0);
`else
    repeat (20) step();
    chk1("nto_req_held", mem_req, 1'b1);
    chk1("nto_flag", fetch_timeout, 1'b0);
    chk1("nto_no_fault", pc_fault, 1'b0);
`endif

    // Reset abandons the transaction; a late ack in IDLE is ignored
    reset = 1'b1; fetch_en = 1'b0;
    step();
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h4444_4444;
    step();
    mem_ack = 1'b0;
    chk1("late_ack_no_valid", ir_valid, 1'b0);
    chk1("late_ack_no_req", mem_req, 1'b0);
    step();
    chk1("late_ack_still_idle", ir_valid, 1'b0);
    chk1("late_ack_no_timeout", fetch_timeout, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cu_fetch.md
Name: cu_fetch

Overview:
- Instruction fetch stage directly upstream of the control unit's decode stage.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Presents each fetched word as IR plus its PC to the decoder over a valid/ready handshake.
- Accepts branch/jump redirects and pipeline stalls from the CU; flags out-of-range or misaligned PCs as a sticky fault that the CU error-catch logic consumes.

Parameters:
- IMEM_DEPTH, 128, instruction memory size in 32-bit words; legal PC range is 0 to 4*IMEM_DEPTH-4.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 15, cycles a request may wait for mem_ack before timeout (optional feature only).

Ports:
- soc_clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- fetch_en  input  1  CU permits fetching.
- stall  input  1  pipeline override from decode; blocks issue of new requests.
- redirect_valid  input  1  one-cycle pulse: load redirect_pc (branch/JAL/JALR).
- redirect_pc  input  32  redirect target.
- mem_req  output  1  instruction memory read request.
- mem_addr  output  32  byte address of the request.
- mem_ack  input  1  memory returns mem_rdata this cycle.
- mem_rdata  input  32  instruction word.
- ir_valid  output  1  ir_out/ir_pc valid for decode.
- ir_ready  input  1  decode accepts the word.
- ir_out  output  32  fetched instruction.
- ir_pc  output  32  PC of ir_out.
- pc_fault  output  1  sticky: illegal PC reached.
- fetch_timeout  output  1  sticky: memory did not ack (0 unless FETCH_TIMEOUT_EN).

Behaviour:
- Reset (async, immediate):
  - State IDLE, pc=RESET_PC.
  - mem_req=0, mem_addr=0, ir_valid=0, ir_out=0, ir_pc=0, pc_fault=0, fetch_timeout=0, squash=0.
  - Reset asserted mid-transaction abandons it; any later mem_ack while in IDLE is ignored.
- States: IDLE, REQ, HOLD, FAULT.
- IDLE:
  - If fetch_en=1 and stall=0, check pc.
  - pc[1:0]!=0 or pc>=4*IMEM_DEPTH -> FAULT.
  - Otherwise -> REQ with mem_req=1 and mem_addr=pc from the next cycle (latency 1).
- REQ:
  - mem_req and mem_addr are held stable until mem_ack. A request is never withdrawn.
  - On mem_ack with squash=0: ir_out<=mem_rdata, ir_pc<=pc, ir_valid<=1, pc<=pc+4, mem_req<=0 -> HOLD. ir_valid rises 1 cycle after ack.
  - On mem_ack with squash=1: data is discarded, squash<=0, mem_req<=0 -> IDLE.
- HOLD:
  - ir_valid, ir_out and ir_pc are held until ir_ready=1.
  - The cycle ir_ready=1 is sampled: ir_valid<=0 -> IDLE. Minimum 3 cycles per instruction.
- Stall:
  - Affects only issue from IDLE.
  - An outstanding request completes; a HOLD word remains presented.
- Redirect (any state except FAULT), priority over pc+4:
  - pc<=redirect_pc.
  - In REQ: squash<=1. If mem_ack arrives the same cycle, that data is discarded immediately -> IDLE.
  - In HOLD: ir_valid<=0 -> IDLE, even if ir_ready=1 the same cycle.
  - A redirect to an illegal target faults at its next issue attempt, not at redirect.
- FAULT:
  - pc_fault=1, mem_req=0, ir_valid=0.
  - Absorbing; only reset leaves it.
- pc+4 uses 32-bit modular arithmetic; wrap past 0xFFFF_FFFC is caught by the range check.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - A 4-bit-or-wider wait counter clears on entry to REQ and increments each REQ cycle without mem_ack.
  - When it reaches MAX_WAIT with no ack: fetch_timeout<=1 and pc_fault<=1 (both sticky) -> FAULT.
  - An ack arriving in the same cycle the count is reached wins.
- Undefined: no counter is built, fetch_timeout is tied 0, and REQ waits indefinitely.

Test Plan:
- Reset, fetch_en=1, memory acks 1 cycle after req with 0x00500093 -> mem_addr=0; ir_valid=1, ir_out=0x00500093, ir_pc=0; next request mem_addr=4.
- ir_ready held 0 for 5 cycles in HOLD -> ir_out stable; no new mem_req until ir_ready=1.
- Redirect to 0x40 while in REQ, ack 2 cycles later with 0xDEADBEEF -> word never presented; next mem_addr=0x40.
- Redirect to 0x200 (IMEM_DEPTH=128) -> next issue enters FAULT, pc_fault=1, mem_req stays 0; assert reset -> pc_fault=0, pc=0.
- stall=1 in IDLE for 4 cycles -> mem_req stays 0; release -> mem_req=1 the following cycle.
- FETCH_TIMEOUT_EN with mem_ack never asserted -> fetch_timeout=1 and pc_fault=1 after 15 REQ cycles; undefined build -> mem_req stays 1 and fetch_timeout=0.
